// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param
// Parametrised vending-machine controller. It accepts 1/2/5-ruble coins up to
// a credit cap and vends when a buy request finds credit >= PRICE. It then pays
// change (or a cancel refund) one coin at a time through a ready/valid
// dispenser handshake, choosing the largest coin that fits each time.
//
// Parameters:
//   PRICE   product price in rubles (1..MAX_SUM)
//   MAX_SUM credit cap; a coin that would exceed it is rejected
//   SUM_W   credit width, 2^SUM_W > MAX_SUM
// Ports:
//   CLK            clock, rising edge
//   reset_n        asynchronous active-low reset
//   coin_valid     coin presented this cycle
//   coin_val       coin code: 0=1, 1=2, 2=5 rubles, 3=invalid
//   buy            purchase request (level)
//   cancel         abort / refund request
//   disp_ready     dispenser accepts coin_out this cycle
//   vend           one-cycle product release pulse
//   coin_reject    one-cycle pulse: previous cycle's coin returned uncredited
//   coin_out_valid change/refund coin offered
//   coin_out_val   offered coin code
//   credit         current credit or remaining payout
//   busy           high in VEND and PAYOUT
module vend_ctrl_param #(
    parameter int PRICE   = 5,
    parameter int MAX_SUM = 12,
    parameter int SUM_W   = 4
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             coin_valid,
    input  logic [1:0]       coin_val,
    input  logic             buy,
    input  logic             cancel,
    input  logic             disp_ready,
    output logic             vend,
    output logic             coin_reject,
    output logic             coin_out_valid,
    output logic [1:0]       coin_out_val,
    output logic [SUM_W-1:0] credit,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        PAYOUT  = 2'd3
    } state_t;

    // Extended-width constants so the coin sum can never wrap.
    localparam logic [SUM_W:0]   L_MAX   = (SUM_W+1)'(MAX_SUM);
    localparam logic [SUM_W:0]   L_PRICE = (SUM_W+1)'(PRICE);
    localparam logic [SUM_W-1:0] L_PRICE_N = SUM_W'(PRICE);

    state_t           r_state;
    logic [SUM_W-1:0] r_credit;
    logic             r_vend;
    logic             r_reject;

    logic [SUM_W:0]   w_coin_amt;
    logic             w_coin_code_ok;
    logic [SUM_W:0]   w_sum;
    logic             w_coin_ok;
    logic             w_can_buy;
    logic [SUM_W-1:0] w_after_vend;
    logic [SUM_W-1:0] w_pay_amt;
    logic [1:0]       w_pay_code;

    // Incoming coin decode and cap check.
    always_comb begin
        w_coin_amt     = '0;
        w_coin_code_ok = 1'b1;
        case (coin_val)
            2'd0:    w_coin_amt = (SUM_W+1)'(1);
            2'd1:    w_coin_amt = (SUM_W+1)'(2);
            2'd2:    w_coin_amt = (SUM_W+1)'(5);
            default: w_coin_code_ok = 1'b0;
        endcase
    end

    assign w_sum        = {1'b0, r_credit} + w_coin_amt;
    assign w_coin_ok    = w_coin_code_ok && (w_sum <= L_MAX);
    assign w_can_buy    = ({1'b0, r_credit} >= L_PRICE);
    assign w_after_vend = r_credit - L_PRICE_N;

    // Greedy change selection from the current credit register.
    always_comb begin
        w_pay_amt  = SUM_W'(1);
        w_pay_code = 2'd0;
        if (r_credit >= SUM_W'(5)) begin
            w_pay_amt  = SUM_W'(5);
            w_pay_code = 2'd2;
        end else if (r_credit >= SUM_W'(2)) begin
            w_pay_amt  = SUM_W'(2);
            w_pay_code = 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_credit <= '0;
            r_vend   <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_vend   <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (coin_valid) begin
                        if (w_coin_ok) begin
                            r_credit <= w_sum[SUM_W-1:0];
                            r_state  <= COLLECT;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (cancel) begin
                        // Whole credit becomes the refund; a coin alongside is bounced.
                        r_state  <= PAYOUT;
                        r_reject <= coin_valid;
                    end else if (buy && w_can_buy) begin
                        r_state  <= VEND;
                        r_vend   <= 1'b1;
                        r_reject <= coin_valid;
                    end else if (coin_valid) begin
                        if (w_coin_ok) begin
                            r_credit <= w_sum[SUM_W-1:0];
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    r_reject <= coin_valid;
                    r_credit <= w_after_vend;
                    r_state  <= (w_after_vend == '0) ? IDLE : PAYOUT;
                end
                PAYOUT: begin
                    r_reject <= coin_valid;
                    if (disp_ready) begin
                        r_credit <= r_credit - w_pay_amt;
                        if (r_credit == w_pay_amt) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign vend           = r_vend;
    assign coin_reject    = r_reject;
    assign credit         = r_credit;
    assign coin_out_valid = (r_state == PAYOUT);
    assign coin_out_val   = w_pay_code;
    assign busy           = (r_state == VEND) || (r_state == PAYOUT);

endmodule

// File: tb/tb_vend_ctrl_param.sv
module tb_vend_ctrl_param;

    logic       clk;
    logic       rst_n;

    // Default-parameter instance signals
    logic       coin_valid, buy, cancel, disp_ready;
    logic [1:0] coin_val;
    logic       vend, coin_reject, coin_out_valid, busy;
    logic [1:0] coin_out_val;
    logic [3:0] credit;

    // PRICE=7 / MAX_SUM=20 / SUM_W=5 instance signals
    logic       p_coin_valid, p_buy, p_cancel, p_disp_ready;
    logic [1:0] p_coin_val;
    logic       p_vend, p_coin_reject, p_coin_out_valid, p_busy;
    logic [1:0] p_coin_out_val;
    logic [4:0] p_credit;

    int n_checks = 0;
    int n_errors = 0;

    vend_ctrl_param u_dut (
        .CLK            (clk),
        .reset_n        (rst_n),
        .coin_valid     (coin_valid),
        .coin_val       (coin_val),
        .buy            (buy),
        .cancel         (cancel),
        .disp_ready     (disp_ready),
        .vend           (vend),
        .coin_reject    (coin_reject),
        .coin_out_valid (coin_out_valid),
        .coin_out_val   (coin_out_val),
        .credit         (credit),
        .busy           (busy)
    );

    vend_ctrl_param #(
        .PRICE   (7),
        .MAX_SUM (20),
        .SUM_W   (5)
    ) u_dut_p (
        .CLK            (clk),
        .reset_n        (rst_n),
        .coin_valid     (p_coin_valid),
        .coin_val       (p_coin_val),
        .buy            (p_buy),
        .cancel         (p_cancel),
        .disp_ready     (p_disp_ready),
        .vend           (p_vend),
        .coin_reject    (p_coin_reject),
        .coin_out_valid (p_coin_out_valid),
        .coin_out_val   (p_coin_out_val),
        .credit         (p_credit),
        .busy           (p_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        coin_valid = 1'b0; coin_val = 2'd0; buy = 1'b0; cancel = 1'b0;
    endtask

    task automatic coin(input logic [1:0] code);
        coin_valid = 1'b1; coin_val = code;
        tick();
        coin_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        disp_ready = 1'b1;
        p_coin_valid = 1'b0; p_coin_val = 2'd0; p_buy = 1'b0;
        p_cancel = 1'b0; p_disp_ready = 1'b1;
        repeat (2) tick();

        // Reset state
        check_eq("rst_credit", int'(credit), 0);
        check_eq("rst_vend", int'(vend), 0);
        check_eq("rst_reject", int'(coin_reject), 0);
        check_eq("rst_outv", int'(coin_out_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores buy and cancel
        buy = 1'b1; cancel = 1'b1;
        tick();
        idle_in();
        check_eq("idle_buy_vend", int'(vend), 0);
        check_eq("idle_buy_busy", int'(busy), 0);

        // Exact pay: 2, 2, 1 then buy; an early buy with credit 2 is ignored
        coin(2'd1);
        check_eq("ex_c1", int'(credit), 2);
        buy = 1'b1; tick(); buy = 1'b0;
        check_eq("ex_lowbuy_vend", int'(vend), 0);
        check_eq("ex_lowbuy_credit", int'(credit), 2);
        coin(2'd1);
        check_eq("ex_c2", int'(credit), 4);
        coin(2'd0);
        check_eq("ex_c3", int'(credit), 5);
        buy = 1'b1; tick(); buy = 1'b0;
        check_eq("ex_vend", int'(vend), 1);
        check_eq("ex_busy", int'(busy), 1);
        check_eq("ex_outv_vend", int'(coin_out_valid), 0);
        tick();
        check_eq("ex_vend_off", int'(vend), 0);
        check_eq("ex_credit0", int'(credit), 0);
        check_eq("ex_outv", int'(coin_out_valid), 0);
        check_eq("ex_busy_off", int'(busy), 0);

        // Change: 5, 5, buy -> one 5-ruble coin back
        coin(2'd2);
        coin(2'd2);
        check_eq("ch_credit10", int'(credit), 10);
        buy = 1'b1; tick(); buy = 1'b0;
        check_eq("ch_vend", int'(vend), 1);
        tick();
        check_eq("ch_outv", int'(coin_out_valid), 1);
        check_eq("ch_outval", int'(coin_out_val), 2);
        check_eq("ch_credit5", int'(credit), 5);
        tick();
        check_eq("ch_credit0", int'(credit), 0);
        check_eq("ch_outv_done", int'(coin_out_valid), 0);

        // Greedy with stall: credit 9, change 4 = 2 + 2
        coin(2'd2);
        coin(2'd1);
        coin(2'd1);
        check_eq("gr_credit9", int'(credit), 9);
        buy = 1'b1; tick(); buy = 1'b0;
        tick();
        check_eq("gr_credit4", int'(credit), 4);
        check_eq("gr_val1", int'(coin_out_val), 1);
        tick();
        check_eq("gr_credit2", int'(credit), 2);
        disp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("gr_stall_credit", int'(credit), 2);
            check_eq("gr_stall_val", int'(coin_out_val), 1);
            check_eq("gr_stall_outv", int'(coin_out_valid), 1);
        end
        disp_ready = 1'b1;
        tick();
        check_eq("gr_credit0", int'(credit), 0);
        check_eq("gr_outv_done", int'(coin_out_valid), 0);

        // Cap and invalid coins
        coin(2'd2);
        coin(2'd2);
        check_eq("cap_credit10", int'(credit), 10);
        coin(2'd2);
        check_eq("cap_reject5", int'(coin_reject), 1);
        check_eq("cap_hold10", int'(credit), 10);
        coin(2'd1);
        check_eq("cap_accept2", int'(coin_reject), 0);
        check_eq("cap_credit12", int'(credit), 12);
        coin(2'd3);
        check_eq("cap_reject_inv", int'(coin_reject), 1);
        check_eq("cap_hold12", int'(credit), 12);
        // Refund 12 = 5 + 5 + 2
        cancel = 1'b1; tick(); cancel = 1'b0;
        check_eq("cap_ref_outv", int'(coin_out_valid), 1);
        check_eq("cap_ref_val5", int'(coin_out_val), 2);
        check_eq("cap_ref_novend", int'(vend), 0);
        tick();
        check_eq("cap_ref_7", int'(credit), 7);
        tick();
        check_eq("cap_ref_2", int'(credit), 2);
        check_eq("cap_ref_val2", int'(coin_out_val), 1);
        tick();
        check_eq("cap_ref_0", int'(credit), 0);
        check_eq("cap_ref_done", int'(busy), 0);

        // Priority: cancel beats buy beats coin; refund 7 = 5 + 2
        coin(2'd2);
        coin(2'd1);
        check_eq("pr_credit7", int'(credit), 7);
        buy = 1'b1; cancel = 1'b1; coin_valid = 1'b1; coin_val = 2'd0;
        tick();
        idle_in();
        check_eq("pr_novend", int'(vend), 0);
        check_eq("pr_reject", int'(coin_reject), 1);
        check_eq("pr_credit", int'(credit), 7);
        check_eq("pr_val5", int'(coin_out_val), 2);
        tick();
        check_eq("pr_credit2", int'(credit), 2);
        check_eq("pr_val2", int'(coin_out_val), 1);
        check_eq("pr_reject_off", int'(coin_reject), 0);
        tick();
        check_eq("pr_credit0", int'(credit), 0);
        check_eq("pr_outv_done", int'(coin_out_valid), 0);

        // Coin during VEND is rejected
        coin(2'd2);
        buy = 1'b1; tick(); buy = 1'b0;
        coin_valid = 1'b1; coin_val = 2'd0;
        tick();
        idle_in();
        check_eq("vd_reject", int'(coin_reject), 1);
        check_eq("vd_credit0", int'(credit), 0);

        // Reset mid-PAYOUT
        disp_ready = 1'b0;
        coin(2'd2);
        coin(2'd2);
        buy = 1'b1; tick(); buy = 1'b0;
        tick();
        check_eq("rp_outv_pre", int'(coin_out_valid), 1);
        check_eq("rp_credit_pre", int'(credit), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rp_outv", int'(coin_out_valid), 0);
        check_eq("rp_credit", int'(credit), 0);
        check_eq("rp_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        disp_ready = 1'b1;
        tick();
        check_eq("rp_idle_busy", int'(busy), 0);
        coin(2'd0);
        check_eq("rp_after_coin", int'(credit), 1);

        // Parameter sweep: PRICE 7, credit 12 -> change 5
        p_coin_valid = 1'b1; p_coin_val = 2'd2; tick();
        p_coin_val = 2'd2; tick();
        p_coin_val = 2'd1; tick();
        p_coin_valid = 1'b0;
        check_eq("pm_credit12", int'(p_credit), 12);
        p_buy = 1'b1; tick(); p_buy = 1'b0;
        check_eq("pm_vend", int'(p_vend), 1);
        tick();
        check_eq("pm_credit5", int'(p_credit), 5);
        check_eq("pm_val5", int'(p_coin_out_val), 2);
        check_eq("pm_outv", int'(p_coin_out_valid), 1);
        tick();
        check_eq("pm_credit0", int'(p_credit), 0);
        check_eq("pm_busy_off", int'(p_busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
